// File: rtl/bus_pkg.sv
// Shared bit-serial bus types: arbiter FSM states, master limit and an index wrap helper.
package bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_BUSY,
        ARB_RELEASE
    } arb_state_e;

    localparam int unsigned ARB_MAX_MASTERS = 16;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/bs_rr_picker.sv
// Combinational rotating-priority picker: first eligible bit at or after i_ptr, with wrap.
module bs_rr_picker #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_elig,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        w_cand   = '0;
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            w_cand = IDX_W'((32'(i_ptr) + i) % N);
            if (!o_valid && i_elig[w_cand]) begin
                o_valid  = 1'b1;
                o_idx    = w_cand;
                o_onehot = N'(1) << w_cand;
            end
        end
    end

endmodule

// File: rtl/bs_arbiter_n.sv
// N-master bit-serial bus arbiter with grant timeout and split-owner FIFO.
// Define BS_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module bs_arbiter_n
    import bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned SPLIT_DEPTH = 2,
    parameter int unsigned GNT_TIMEOUT = 16,
    parameter int unsigned IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_MASTERS-1:0] req_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic [IDX_W-1:0]       msel_o,
    input  logic                   frame_active_i,
    input  logic                   split_start_i,
    input  logic                   split_done_i,
    output logic                   split_pending_o,
    output logic [NUM_MASTERS-1:0] split_blocked_o,
    output logic                   timeout_o,
    output logic                   split_ovf_o
);

    localparam int unsigned QW = (SPLIT_DEPTH > 1) ? $clog2(SPLIT_DEPTH) : 1;
    localparam int unsigned CW = $clog2(SPLIT_DEPTH + 1);
    localparam int unsigned TW = $clog2(GNT_TIMEOUT);

    arb_state_e             r_state;
    logic [NUM_MASTERS-1:0] r_gnt;
    logic [IDX_W-1:0]       r_msel;
    logic [IDX_W-1:0]       r_ptr;
    logic [TW-1:0]          r_tcnt;
    logic [IDX_W-1:0]       r_q [SPLIT_DEPTH];
    logic [QW-1:0]          r_wr;
    logic [QW-1:0]          r_rd;
    logic [CW-1:0]          r_cnt;
    logic [NUM_MASTERS-1:0] r_blocked;
    logic                   r_ret_flag;
    logic [IDX_W-1:0]       r_ret_idx;
    logic                   r_ret_gnt;
    logic                   r_timeout;
    logic                   r_ovf;

    logic [NUM_MASTERS-1:0] w_elig;
    logic [IDX_W-1:0]       w_pick_ptr;
    logic [NUM_MASTERS-1:0] w_pick_onehot;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_valid;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_push_ok;
    logic [IDX_W-1:0]       w_head;
    logic [NUM_MASTERS-1:0] w_blocked_d;

    assign w_elig = req_i & ~r_blocked;
`ifdef BS_ARB_FIXED_PRIO_EN
    assign w_pick_ptr = '0;
`else
    assign w_pick_ptr = r_ptr;
`endif

    bs_rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_elig   (w_elig),
        .i_ptr    (w_pick_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    // A full queue still accepts a push when a pop frees a slot on the same edge.
    assign w_push    = (r_state == ARB_BUSY) && split_start_i;
    assign w_pop     = split_done_i && (r_cnt != '0);
    assign w_push_ok = w_push && ((r_cnt != CW'(SPLIT_DEPTH)) || w_pop);
    assign w_head    = r_q[r_rd];

    always_comb begin
        w_blocked_d = r_blocked;
        if (w_pop) w_blocked_d[w_head] = 1'b0;
        if (w_push_ok) w_blocked_d[r_msel] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ARB_IDLE;
            r_gnt      <= '0;
            r_msel     <= '0;
            r_ptr      <= '0;
            r_tcnt     <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_cnt      <= '0;
            r_blocked  <= '0;
            r_ret_flag <= 1'b0;
            r_ret_idx  <= '0;
            r_ret_gnt  <= 1'b0;
            r_timeout  <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            unique case (r_state)
                ARB_IDLE: begin
                    r_tcnt <= '0;
                    if (r_ret_flag) begin
                        r_gnt      <= NUM_MASTERS'(1) << r_ret_idx;
                        r_msel     <= r_ret_idx;
                        r_ret_flag <= 1'b0;
                        r_ret_gnt  <= 1'b1;
                        r_state    <= ARB_GRANT;
                    end else if (w_pick_valid) begin
                        r_gnt     <= w_pick_onehot;
                        r_msel    <= w_pick_idx;
                        r_ret_gnt <= 1'b0;
                        r_state   <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (frame_active_i) begin
                        r_state <= ARB_BUSY;
                    end else if (r_tcnt == TW'(GNT_TIMEOUT - 1)) begin
                        r_timeout <= 1'b1;
                        r_gnt     <= '0;
                        r_ptr     <= IDX_W'(wrap_inc(32'(r_msel), NUM_MASTERS));
                        r_state   <= ARB_IDLE;
                        // A revoked split-return grant is re-offered rather than lost.
                        if (r_ret_gnt) begin
                            r_ret_flag <= 1'b1;
                            r_ret_idx  <= r_msel;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                ARB_BUSY: begin
                    if (split_start_i || !frame_active_i) begin
                        r_gnt   <= '0;
                        r_state <= ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    r_ptr   <= IDX_W'(wrap_inc(32'(r_msel), NUM_MASTERS));
                    r_state <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase

            if (w_pop) begin
                r_rd       <= QW'(wrap_inc(32'(r_rd), SPLIT_DEPTH));
                r_ret_flag <= 1'b1;
                r_ret_idx  <= w_head;
            end
            if (w_push_ok) begin
                r_q[r_wr] <= r_msel;
                r_wr      <= QW'(wrap_inc(32'(r_wr), SPLIT_DEPTH));
            end
            if (w_push && !w_push_ok) r_ovf <= 1'b1;
            if (w_push_ok && !w_pop) r_cnt <= r_cnt + 1'b1;
            else if (!w_push_ok && w_pop) r_cnt <= r_cnt - 1'b1;
            r_blocked <= w_blocked_d;
        end
    end

    assign gnt_o           = r_gnt;
    assign msel_o          = r_msel;
    assign split_pending_o = (r_cnt != '0);
    assign split_blocked_o = r_blocked;
    assign timeout_o       = r_timeout;
    assign split_ovf_o     = r_ovf;

endmodule

// File: tb/tb_bs_arbiter_n.sv
// Scoreboard bench for bs_arbiter_n: expected grant owners queued at stimulus, checked at grant.
module tb_bs_arbiter_n;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] msel;
    logic       frame;
    logic       sp_start;
    logic       sp_done;
    logic       pending;
    logic [3:0] blocked;
    logic       tmo;
    logic       ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int sb[$];
    int mptr    = 0;

    bs_arbiter_n #(
        .NUM_MASTERS (4),
        .SPLIT_DEPTH (2),
        .GNT_TIMEOUT (16)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_i           (req),
        .gnt_o           (gnt),
        .msel_o          (msel),
        .frame_active_i  (frame),
        .split_start_i   (sp_start),
        .split_done_i    (sp_done),
        .split_pending_o (pending),
        .split_blocked_o (blocked),
        .timeout_o       (tmo),
        .split_ovf_o     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: first requester at or after ptr, with wrap.
    function automatic int pick(input logic [3:0] elig, input int ptr);
        for (int i = 0; i < 4; i++) begin
            if (elig[(ptr + i) % 4]) return (ptr + i) % 4;
        end
        return -1;
    endfunction

    task automatic wait_grant(input string tag);
        int n;
        int exp;
        n = 0;
        while (gnt == 4'b0 && n < 50) begin
            step();
            n++;
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(gnt), 32'(0));
        end else begin
            exp = sb.pop_front();
            chk({tag, "_gnt"}, 32'(gnt), 32'(4'b1 << exp));
            chk({tag, "_msel"}, 32'(msel), 32'(exp));
        end
    endtask

    task automatic do_frame(input int cycles, input string tag);
        frame = 1'b1;
        repeat (cycles) step();
        frame = 1'b0;
        step();
        chk({tag, "_release_gnt"}, 32'(gnt), 32'(0));
        mptr = (int'(msel) + 1) % 4;
    endtask

    task automatic split_current(input string tag);
        frame = 1'b1;
        step();
        sp_start = 1'b1;
        step();
        sp_start = 1'b0;
        frame    = 1'b0;
        chk({tag, "_split_gnt"}, 32'(gnt), 32'(0));
        mptr = (int'(msel) + 1) % 4;
    endtask

    task automatic pulse_done();
        sp_done = 1'b1;
        step();
        sp_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; frame = 1'b0; sp_start = 1'b0; sp_done = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_msel", 32'(msel), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_blocked", 32'(blocked), 0);
        chk("rst_tmo", 32'(tmo), 0);
        chk("rst_ovf", 32'(ovf), 0);

        // Round-robin sweep with 4-cycle frames.
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(i % 4);
            wait_grant("rr");
            if (i == 4) req = 4'b0;
            do_frame(4, "rr");
        end

        // Grant timeout: M2 holds the grant 16 cycles, then M3 is next.
        req = 4'b1100;
        sb.push_back(pick(req, mptr));
        wait_grant("to_first");
        begin
            int held;
            held = 1;
            while (gnt == 4'b0100 && held < 40) begin
                step();
                if (gnt == 4'b0100) held++;
            end
            chk("to_hold_cycles", 32'(held), 16);
        end
        chk("to_pulse", 32'(tmo), 1);
        chk("to_gnt_cleared", 32'(gnt), 0);
        sb.push_back(3);
        wait_grant("to_next");
        chk("to_pulse_end", 32'(tmo), 0);
        req = 4'b0;
        do_frame(2, "to");

        // Split from M1, M1 excluded, split return beats a requesting M0.
        req = 4'b0010;
        sb.push_back(1);
        wait_grant("sp_m1");
        split_current("sp_m1");
        chk("sp_blocked", 32'(blocked), 32'(4'b0010));
        chk("sp_pending", 32'(pending), 1);
        req = 4'b0011;
        sb.push_back(0);
        wait_grant("sp_excl");
        req = 4'b0001;
        frame = 1'b1;
        step();
        pulse_done();
        chk("sp_done_blocked", 32'(blocked), 0);
        chk("sp_done_pending", 32'(pending), 0);
        frame = 1'b0;
        step();
        chk("sp_rel_gnt", 32'(gnt), 0);
        mptr = 1;
        sb.push_back(1);
        wait_grant("sp_return");
        req = 4'b0;
        do_frame(2, "sp_return");

        // Queue overflow and FIFO return order.
        req = 4'b0001;
        sb.push_back(pick(req, mptr));
        wait_grant("ovf_m0");
        split_current("ovf_m0");
        req = 4'b0100;
        sb.push_back(2);
        wait_grant("ovf_m2");
        split_current("ovf_m2");
        req = 4'b1000;
        sb.push_back(3);
        wait_grant("ovf_m3");
        split_current("ovf_m3");
        req = 4'b0;
        chk("ovf_flag", 32'(ovf), 1);
        chk("ovf_blocked", 32'(blocked), 32'(4'b0101));
        chk("ovf_pending", 32'(pending), 1);
        pulse_done();
        sb.push_back(0);
        wait_grant("ovf_ret0");
        chk("ovf_ret0_blocked", 32'(blocked), 32'(4'b0100));
        do_frame(2, "ovf_ret0");
        pulse_done();
        sb.push_back(2);
        wait_grant("ovf_ret2");
        chk("ovf_ret2_blocked", 32'(blocked), 0);
        chk("ovf_ret2_pending", 32'(pending), 0);
        do_frame(2, "ovf_ret2");

        // Same-cycle push and pop with one entry queued.
        req = 4'b0001;
        sb.push_back(pick(req, mptr));
        wait_grant("pp_m0");
        split_current("pp_m0");
        req = 4'b0010;
        sb.push_back(1);
        wait_grant("pp_m1");
        frame = 1'b1;
        step();
        sp_start = 1'b1;
        sp_done  = 1'b1;
        step();
        sp_start = 1'b0;
        sp_done  = 1'b0;
        frame    = 1'b0;
        req      = 4'b0;
        chk("pp_pending", 32'(pending), 1);
        chk("pp_blocked", 32'(blocked), 32'(4'b0010));
        sb.push_back(0);
        wait_grant("pp_ret0");
        do_frame(2, "pp_ret0");
        pulse_done();
        chk("pp_drained", 32'(pending), 0);
        sb.push_back(1);
        wait_grant("pp_ret1");
        do_frame(2, "pp_ret1");

        // Reset while BUSY with a split queued.
        req = 4'b0001;
        sb.push_back(pick(req, mptr));
        wait_grant("rb_m0");
        split_current("rb_m0");
        req = 4'b0100;
        sb.push_back(2);
        wait_grant("rb_m2");
        frame = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; frame = 1'b0; req = 4'b0;
        chk("rb_gnt", 32'(gnt), 0);
        chk("rb_blocked", 32'(blocked), 0);
        chk("rb_pending", 32'(pending), 0);
        chk("rb_ovf", 32'(ovf), 0);
        mptr = 0;

        // Two requesters M1 and M3: fixed priority always M1, round-robin alternates.
        req = 4'b1010;
        for (int r = 0; r < 3; r++) begin
`ifdef BS_ARB_FIXED_PRIO_EN
            sb.push_back(pick(4'b1010, 0));
`else
            sb.push_back(pick(4'b1010, mptr));
`endif
            wait_grant("prio");
            if (r == 2) req = 4'b0;
            do_frame(2, "prio");
        end

        chk("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
